// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline front-end control logic.
//   - Opcode and func encodings as decoded from the IF/ID segment.
//   - reg_idx_t: 4-bit architectural register index.
//   - state_t:   hazard sequencer states.
package pipe_pkg;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_CTRL = 2'b10;
  localparam logic [1:0] OP_SYS  = 2'b11;

  localparam logic [1:0] FUNC_LOAD  = 2'b00;
  localparam logic [1:0] FUNC_STORE = 2'b01;

  typedef logic [3:0] reg_idx_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_VEC   = 2'd3
  } state_t;

endpackage

// File: rtl/src_use_decode.sv
// Source-operand usage decoder for the instruction in ID.
// Ports:
//   op, func  in  opcode / function fields from IF/ID
//   imm       in  immediate flag (rs2 replaced by an immediate)
//   use_rs1   out rs1 is read (store data)
//   use_rs2   out rs2 is read
//   use_rs3   out rs3 is read
module src_use_decode
  import pipe_pkg::*;
(
  input  logic [1:0] op,
  input  logic [1:0] func,
  input  logic       imm,
  output logic       use_rs1,
  output logic       use_rs2,
  output logic       use_rs3
);

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rs3 = 1'b0;
    case (op)
      OP_ALU: begin
        use_rs3 = 1'b1;
        use_rs2 = !imm;
      end
      OP_MEM: begin
        // Undefined MEM funcs read nothing, so they never stall.
        if (func == FUNC_LOAD) begin
          use_rs3 = 1'b1;
        end else if (func == FUNC_STORE) begin
          use_rs3 = 1'b1;
          use_rs1 = 1'b1;
        end
      end
      OP_CTRL: use_rs3 = !imm;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard sequencer for the five-stage pipeline.
// Resolves load-use stalls, taken-branch flushes and multi-cycle vector ops.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   id_op/func/I/V/rs1/rs3/rs2  decoded fields of the instruction in ID
//   ex_mem_read, ex_rd       EX holds a load and its destination register
//   ex_branch_taken          branch in EX resolved taken this cycle
//   pc_en, ifid_en           front-end advance enables
//   ifid_flush, idex_flush   NOP into IF/ID, bubble into ID/EX
//   vec_busy, vec_lane       vector sequencing status and current lane
//   dbg_state                current sequencer state (observation only)
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               id_op,
  input  logic [1:0]               id_func,
  input  logic                     id_I,
  input  logic                     id_V,
  input  reg_idx_t                 id_rs1,
  input  reg_idx_t                 id_rs3,
  input  reg_idx_t                 id_rs2,
  input  logic                     ex_mem_read,
  input  reg_idx_t                 ex_rd,
  input  logic                     ex_branch_taken,
  output logic                     pc_en,
  output logic                     ifid_en,
  output logic                     ifid_flush,
  output logic                     idex_flush,
  output logic                     vec_busy,
  output logic [$clog2(LANES)-1:0] vec_lane,
  output state_t                   dbg_state
);

  localparam int             LW        = $clog2(LANES);
  localparam logic [LW-1:0]  LANE_LAST = LW'(LANES - 1);
  localparam logic [1:0]     BUB_INIT  = 2'(LOAD_BUBBLES - 1);

  state_t        state, state_nxt;
  logic [LW-1:0] lane_cnt, lane_nxt;
  logic [1:0]    bub_cnt, bub_nxt;

  logic use_rs1, use_rs2, use_rs3;
  logic load_use, vec_start;

  src_use_decode u_src_use_decode (
    .op      (id_op),
    .func    (id_func),
    .imm     (id_I),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .use_rs3 (use_rs3)
  );

  assign load_use = ex_mem_read &&
                    ((use_rs1 && (id_rs1 == ex_rd)) ||
                     (use_rs2 && (id_rs2 == ex_rd)) ||
                     (use_rs3 && (id_rs3 == ex_rd)));

  assign vec_start = (id_op == OP_ALU) && id_V;

  assign dbg_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_RUN;
      lane_cnt <= '0;
      bub_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      lane_cnt <= lane_nxt;
      bub_cnt  <= bub_nxt;
    end
  end

  // Next-state logic.
  // bub_cnt holds the number of S_LOAD cycles still to run, so the detect
  // cycle plus the S_LOAD cycles add up to LOAD_BUBBLES. With a single
  // bubble the detect cycle is the whole stall and S_LOAD is skipped.
  always_comb begin
    state_nxt = state;
    lane_nxt  = lane_cnt;
    bub_nxt   = bub_cnt;
    case (state)
      S_RUN: begin
        if (ex_branch_taken) begin
          state_nxt = S_FLUSH;
        end else if (vec_start) begin
          // Lane 0 is processed in the entry cycle.
          state_nxt = S_VEC;
          lane_nxt  = LW'(1);
        end else if (load_use) begin
          bub_nxt   = BUB_INIT;
          state_nxt = (BUB_INIT == 2'd0) ? S_RUN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (ex_branch_taken) begin
          state_nxt = S_FLUSH;
          bub_nxt   = '0;
        end else if (bub_cnt <= 2'd1) begin
          state_nxt = S_RUN;
          bub_nxt   = '0;
        end else begin
          bub_nxt = bub_cnt - 2'd1;
        end
      end
      S_FLUSH: state_nxt = S_RUN;
      S_VEC: begin
        // EX holds the vector op, so a branch indication here is ignored.
        if (lane_cnt == LANE_LAST) begin
          state_nxt = S_RUN;
          lane_nxt  = '0;
        end else begin
          lane_nxt = lane_cnt + LW'(1);
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // Output logic: conditions detected in S_RUN act in the same cycle.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    vec_busy   = 1'b0;
    vec_lane   = lane_cnt;
    if (!rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      vec_lane   = '0;
    end else begin
      case (state)
        S_RUN: begin
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (vec_start) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            vec_busy = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        S_LOAD: begin
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        S_FLUSH: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        S_VEC: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          vec_busy = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Two instances share one stimulus
// stream: dut_a (LOAD_BUBBLES=1) and dut_b (LOAD_BUBBLES=3), both LANES=4.
// Expected output words: {pc_en, ifid_en, ifid_flush, idex_flush, vec_busy, vec_lane[1:0]}.
module tb_pipeline_hazard_ctrl;
  import pipe_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic [1:0] id_op = 2'b11, id_func = 2'b00;
  logic       id_I = 1'b0, id_V = 1'b0;
  logic [3:0] id_rs1 = '0, id_rs3 = '0, id_rs2 = '0;
  logic       ex_mem_read = 1'b0;
  logic [3:0] ex_rd = '0;
  logic       ex_branch_taken = 1'b0;

  logic       a_pc_en, a_ifid_en, a_ifid_flush, a_idex_flush, a_vec_busy;
  logic [1:0] a_vec_lane;
  state_t     a_dbg;
  logic       b_pc_en, b_ifid_en, b_ifid_flush, b_idex_flush, b_vec_busy;
  logic [1:0] b_vec_lane;
  state_t     b_dbg;

  pipeline_hazard_ctrl #(.LANES(4), .LOAD_BUBBLES(1)) dut_a (
    .clk(clk), .rst(rst), .id_op(id_op), .id_func(id_func), .id_I(id_I), .id_V(id_V),
    .id_rs1(id_rs1), .id_rs3(id_rs3), .id_rs2(id_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .pc_en(a_pc_en), .ifid_en(a_ifid_en),
    .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush), .vec_busy(a_vec_busy),
    .vec_lane(a_vec_lane), .dbg_state(a_dbg)
  );

  pipeline_hazard_ctrl #(.LANES(4), .LOAD_BUBBLES(3)) dut_b (
    .clk(clk), .rst(rst), .id_op(id_op), .id_func(id_func), .id_I(id_I), .id_V(id_V),
    .id_rs1(id_rs1), .id_rs3(id_rs3), .id_rs2(id_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .pc_en(b_pc_en), .ifid_en(b_ifid_en),
    .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush), .vec_busy(b_vec_busy),
    .vec_lane(b_vec_lane), .dbg_state(b_dbg)
  );

  localparam logic [6:0] E_RUN   = 7'b1100000;
  localparam logic [6:0] E_STALL = 7'b0001000;
  localparam logic [6:0] E_FLUSH = 7'b1111000;
  localparam logic [6:0] E_RST   = 7'b0011000;

  function automatic logic [6:0] e_vec(input logic [1:0] lane);
    return {5'b00001, lane};
  endfunction

  // Scoreboard
  logic [13:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_vec    = 0;
  logic [13:0] mon_e;
  logic [6:0]  got_a, got_b;

  // Monitor: one expected word per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      got_a = {a_pc_en, a_ifid_en, a_ifid_flush, a_idex_flush, a_vec_busy, a_vec_lane};
      got_b = {b_pc_en, b_ifid_en, b_ifid_flush, b_idex_flush, b_vec_busy, b_vec_lane};
      n_checks++;
      if (got_a !== mon_e[13:7]) begin
        n_fail++;
        $display("FAIL lb1 vector %0d: got %b expected %b", n_vec, got_a, mon_e[13:7]);
      end
      n_checks++;
      if (got_b !== mon_e[6:0]) begin
        n_fail++;
        $display("FAIL lb3 vector %0d: got %b expected %b", n_vec, got_b, mon_e[6:0]);
      end
      n_vec++;
    end
  end

  // Driver tasks
  task automatic drive(input logic r, input logic [1:0] op, input logic [1:0] fn,
                       input logic imm, input logic v, input logic [3:0] r1,
                       input logic [3:0] r3, input logic [3:0] r2, input logic mr,
                       input logic [3:0] rd, input logic br,
                       input logic [6:0] ea, input logic [6:0] eb);
    rst = r; id_op = op; id_func = fn; id_I = imm; id_V = v;
    id_rs1 = r1; id_rs3 = r3; id_rs2 = r2;
    ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br;
    exp_q.push_back({ea, eb});
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic [6:0] ea, input logic [6:0] eb);
    drive(1'b1, OP_SYS, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, ea, eb);
  endtask

  task automatic vec_op(input logic [6:0] ea, input logic [6:0] eb);
    drive(1'b1, OP_ALU, 2'b00, 1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 1'b0, ea, eb);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset state
    drive(1'b0, OP_SYS, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, E_RST, E_RST);
    drive(1'b0, OP_SYS, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, E_RST, E_RST);
    nop(E_RUN, E_RUN);

    // Load-use on ALU rs2: 1 stall cycle vs 3 stall cycles
    drive(1'b1, OP_ALU, 2'b00, 1'b0, 1'b0, 4'd1, 4'd3, 4'd5, 1'b1, 4'd5, 1'b0, E_STALL, E_STALL);
    drive(1'b1, OP_ALU, 2'b00, 1'b0, 1'b0, 4'd1, 4'd3, 4'd5, 1'b0, 4'd5, 1'b0, E_RUN, E_STALL);
    drive(1'b1, OP_ALU, 2'b00, 1'b0, 1'b0, 4'd1, 4'd3, 4'd5, 1'b0, 4'd5, 1'b0, E_RUN, E_STALL);
    drive(1'b1, OP_ALU, 2'b00, 1'b0, 1'b0, 4'd1, 4'd3, 4'd5, 1'b0, 4'd5, 1'b0, E_RUN, E_RUN);

    // Immediate form does not read rs2: no false hazard
    drive(1'b1, OP_ALU, 2'b00, 1'b1, 1'b0, 4'd1, 4'd3, 4'd5, 1'b1, 4'd5, 1'b0, E_RUN, E_RUN);

    // Store data (rs1) hazard, full stall
    drive(1'b1, OP_MEM, 2'b01, 1'b0, 1'b0, 4'd7, 4'd2, 4'd0, 1'b1, 4'd7, 1'b0, E_STALL, E_STALL);
    drive(1'b1, OP_MEM, 2'b01, 1'b0, 1'b0, 4'd7, 4'd2, 4'd0, 1'b0, 4'd7, 1'b0, E_RUN, E_STALL);
    drive(1'b1, OP_MEM, 2'b01, 1'b0, 1'b0, 4'd7, 4'd2, 4'd0, 1'b0, 4'd7, 1'b0, E_RUN, E_STALL);
    drive(1'b1, OP_MEM, 2'b01, 1'b0, 1'b0, 4'd7, 4'd2, 4'd0, 1'b0, 4'd7, 1'b0, E_RUN, E_RUN);

    // Store hazard, branch on stall cycle 2 preempts into flush
    drive(1'b1, OP_MEM, 2'b01, 1'b0, 1'b0, 4'd7, 4'd2, 4'd0, 1'b1, 4'd7, 1'b0, E_STALL, E_STALL);
    drive(1'b1, OP_MEM, 2'b01, 1'b0, 1'b0, 4'd7, 4'd2, 4'd0, 1'b0, 4'd7, 1'b1, E_FLUSH, E_FLUSH);
    nop(E_FLUSH, E_FLUSH);
    nop(E_RUN, E_RUN);

    // Branch coincident with a load-use match: branch wins
    drive(1'b1, OP_ALU, 2'b00, 1'b0, 1'b0, 4'd1, 4'd5, 4'd2, 1'b1, 4'd5, 1'b1, E_FLUSH, E_FLUSH);
    nop(E_FLUSH, E_FLUSH);
    nop(E_RUN, E_RUN);

    // Vector op: lanes 0..3, branch during S_VEC ignored
    vec_op(e_vec(2'd0), e_vec(2'd0));
    drive(1'b1, OP_SYS, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1,
          e_vec(2'd1), e_vec(2'd1));
    nop(e_vec(2'd2), e_vec(2'd2));
    nop(e_vec(2'd3), e_vec(2'd3));

    // Dependent load right after the vector op
    drive(1'b1, OP_ALU, 2'b00, 1'b0, 1'b0, 4'd1, 4'd4, 4'd2, 1'b1, 4'd4, 1'b0, E_STALL, E_STALL);
    nop(E_RUN, E_STALL);
    nop(E_RUN, E_STALL);
    nop(E_RUN, E_RUN);

    // Reset mid-vector, then a fresh vector op starts from lane 0
    vec_op(e_vec(2'd0), e_vec(2'd0));
    nop(e_vec(2'd1), e_vec(2'd1));
    drive(1'b0, OP_SYS, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, E_RST, E_RST);
    nop(E_RUN, E_RUN);
    vec_op(e_vec(2'd0), e_vec(2'd0));
    nop(e_vec(2'd1), e_vec(2'd1));
    nop(e_vec(2'd2), e_vec(2'd2));
    nop(e_vec(2'd3), e_vec(2'd3));
    nop(E_RUN, E_RUN);

    // Source-usage corner cases
    drive(1'b1, OP_MEM, 2'b00, 1'b0, 1'b0, 4'd0, 4'd9, 4'd6, 1'b1, 4'd6, 1'b0, E_RUN, E_RUN);
    drive(1'b1, OP_SYS, 2'b00, 1'b0, 1'b0, 4'd6, 4'd6, 4'd6, 1'b1, 4'd6, 1'b0, E_RUN, E_RUN);
    drive(1'b1, OP_CTRL, 2'b00, 1'b1, 1'b0, 4'd0, 4'd6, 4'd0, 1'b1, 4'd6, 1'b0, E_RUN, E_RUN);
    drive(1'b1, OP_CTRL, 2'b00, 1'b0, 1'b0, 4'd0, 4'd6, 4'd0, 1'b1, 4'd6, 1'b0, E_STALL, E_STALL);
    nop(E_RUN, E_STALL);
    nop(E_RUN, E_STALL);
    nop(E_RUN, E_RUN);
    drive(1'b1, OP_ALU, 2'b00, 1'b0, 1'b0, 4'd0, 4'd1, 4'd6, 1'b0, 4'd6, 1'b0, E_RUN, E_RUN);
    drive(1'b1, OP_ALU, 2'b00, 1'b0, 1'b0, 4'd6, 4'd1, 4'd2, 1'b1, 4'd6, 1'b0, E_RUN, E_RUN);
    drive(1'b1, OP_MEM, 2'b01, 1'b0, 1'b0, 4'd0, 4'd1, 4'd6, 1'b1, 4'd6, 1'b0, E_RUN, E_RUN);
    drive(1'b1, OP_MEM, 2'b00, 1'b0, 1'b0, 4'd0, 4'd6, 4'd0, 1'b1, 4'd6, 1'b0, E_STALL, E_STALL);
    nop(E_RUN, E_STALL);
    nop(E_RUN, E_STALL);
    nop(E_RUN, E_RUN);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
